eq2_pattern_gen: RTL and testbench
==================================

Name: eq2_pattern_gen

Overview:
Sequential stimulus source for the 2-bit equality comparator datapath. Its output is the operand pair for the comparator, not a comparison result. On a start command it emits a burst of 2-bit symbol pairs (a, b) over a valid/ready handshake. a and b are identical on every beat except one optional, deliberately corrupted beat. The comparator on the far end must report aeqb=1 on every beat except that one. Used for on-board self-test of the comparator path.

Parameters:
LFSR_SEED, 8'hA5, initial LFSR state at every start; must be nonzero (0 is replaced by 8'h01).
ERR_IDX, 3, zero-based beat index corrupted when injection is armed.

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset
start  input  1  begin burst; sampled only in IDLE
mode  input  2  pattern: 0 count, 1 LFSR, 2 fixed, 3 walking
fixed_val  input  2  symbol for mode 2
len  input  8  beats in burst, 0..255
inject_err  input  1  arm single-beat corruption; sampled with start
a  output  2  operand A symbol
b  output  2  operand B symbol
valid  output  1  a/b hold a beat
ready  input  1  downstream accepts beat when valid & ready
err_beat  output  1  high while the current beat is the corrupted one
busy  output  1  high in RUN
done  output  1  one-cycle pulse at burst end

Behaviour:
- Reset (reset_n=0 at a rising edge): state=IDLE. a=0, b=0, valid=0, err_beat=0, busy=0, done=0. Beat counter=0, LFSR=LFSR_SEED.
- Reset has priority over everything. Asserting it mid-burst aborts the burst immediately; done is not pulsed.
- FSM states:
  - IDLE: on start=1, capture mode, fixed_val, len and inject_err; load LFSR=LFSR_SEED and beat index=0. If len=0, go to DONE; otherwise go to RUN.
  - RUN: beats are issued until the accepted count reaches the captured len, then go to DONE.
  - DONE: done=1 for exactly one cycle, then return to IDLE.
- start is ignored outside IDLE. Inputs captured at start stay fixed for the whole burst; changes to the live inputs mid-burst have no effect.
- Latency: start high at edge N gives valid=1 with beat 0 at edge N+1. busy=1 from edge N+1 until the last beat is accepted.
- Handshake:
  - A beat transfers on a rising edge where valid & ready.
  - While valid & !ready, a, b and err_beat hold stable.
  - valid never drops without a transfer, except on reset.
  - If ready stays high, one beat transfers per cycle with no bubbles.
  - After the final transfer, valid=0 on the next cycle, coincident with done=1.
- Symbol for beat i (a; b = a unless corrupted):
  - mode 0 (count): i[1:0], so 0,1,2,3,0,...
  - mode 1 (LFSR): lfsr[1:0]. The LFSR advances only on a transfer: next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - mode 2 (fixed): the captured fixed_val on every beat.
  - mode 3 (walking): 2'b01 on even beats, 2'b10 on odd beats.
- Corruption: if inject_err was captured and i == ERR_IDX < len, then b = a ^ 2'b01 and err_beat=1 on that beat. If ERR_IDX >= len, no beat is corrupted.
- Beat counter is 8 bits and never wraps inside a burst, since at most 255 beats are issued.
- If start and reset_n=0 arrive together, reset wins.

Test Plan:
1. Reset check: reset_n=0 for 2 cycles with start=1 -> a=b=0, valid=busy=done=0, FSM in IDLE.
2. Count mode: mode=0, len=6, ready=1 -> a=b sequence 0,1,2,3,0,1 on 6 consecutive cycles; done pulses one cycle after the last beat; busy high for exactly 6 cycles.
3. LFSR mode: mode=1, len=3, seed 8'hA5, ready=1 -> a=b=01, 10, 01 (LFSR states A5, 4A, 95).
4. Backpressure: mode=3, len=4, ready toggling 1,0,0,1,1,0,1 -> accepted beats are 01,10,01,10 in order; a/b stable while ready=0; total of 4 transfers.
5. Error injection: mode=2, fixed_val=2'b10, len=5, inject_err=1 -> beat 3 has a=10, b=11, err_beat=1; all other beats a=b=10; repeating with len=3 gives no corrupted beat.
6. Edge cases:
   - len=0 -> done pulses at edge N+1 with no valid.
   - reset_n=0 during beat 2 of a len=10 burst -> outputs return to reset values next edge; no done pulse.
   - start held through a burst -> exactly one burst runs, and the next burst starts only from IDLE.

Source files
------------

// File: rtl/eq2_pattern_gen_if.sv
// Operand-pair beat channel from the pattern generator to the comparator.
// Carries a/b symbols, err_beat marker and the valid/ready handshake.
interface eq2_pattern_gen_if;
    logic [1:0] a;
    logic [1:0] b;
    logic       valid;
    logic       ready;
    logic       err_beat;

    modport master (
        output a,
        output b,
        output valid,
        output err_beat,
        input  ready
    );

    modport slave (
        input  a,
        input  b,
        input  valid,
        input  err_beat,
        output ready
    );
endinterface

// File: rtl/eq2_pattern_gen.sv
// Burst source of 2-bit operand pairs for 2-bit equality comparator self-test.
// Ports: clk, reset_n (sync, active low), start/mode/fixed_val/len/inject_err
// command inputs, bus (master: a, b, valid, err_beat out; ready in),
// busy (burst running) and done (one-cycle end-of-burst pulse).
module eq2_pattern_gen #(
    parameter logic [7:0]  LFSR_SEED = 8'hA5,
    parameter int unsigned ERR_IDX   = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [1:0]       fixed_val,
    input  logic [7:0]       len,
    input  logic             inject_err,
    eq2_pattern_gen_if.master bus,
    output logic             busy,
    output logic             done
);

    // An all-zero LFSR would lock up, so a zero seed is forced to 1.
    localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state, state_n;
    logic [1:0] mode_q, mode_n;
    logic [1:0] fix_q, fix_n;
    logic [7:0] len_q, len_n;
    logic       inj_q, inj_n;
    logic [7:0] idx, idx_n;
    logic [7:0] lfsr, lfsr_n;

    logic       fire;
    logic       corrupt;
    logic [1:0] sym;
    logic [7:0] lfsr_step;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            mode_q <= 2'd0;
            fix_q  <= 2'd0;
            len_q  <= 8'd0;
            inj_q  <= 1'b0;
            idx    <= 8'd0;
            lfsr   <= SEED;
        end else begin
            state  <= state_n;
            mode_q <= mode_n;
            fix_q  <= fix_n;
            len_q  <= len_n;
            inj_q  <= inj_n;
            idx    <= idx_n;
            lfsr   <= lfsr_n;
        end
    end

    assign lfsr_step = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign fire      = (state == RUN) && bus.ready;

    always_comb begin
        state_n = state;
        mode_n  = mode_q;
        fix_n   = fix_q;
        len_n   = len_q;
        inj_n   = inj_q;
        idx_n   = idx;
        lfsr_n  = lfsr;
        unique case (state)
            IDLE: begin
                if (start) begin
                    mode_n  = mode;
                    fix_n   = fixed_val;
                    len_n   = len;
                    inj_n   = inject_err;
                    idx_n   = 8'd0;
                    lfsr_n  = SEED;
                    state_n = (len == 8'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                // Index and LFSR move only on a transfer, which keeps
                // the beat stable under backpressure.
                if (fire) begin
                    idx_n  = idx + 8'd1;
                    lfsr_n = lfsr_step;
                    if (idx + 8'd1 == len_q) begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_comb begin
        sym = 2'b00;
        unique case (mode_q)
            2'd0: sym = idx[1:0];
            2'd1: sym = lfsr[1:0];
            2'd2: sym = fix_q;
            2'd3: sym = idx[0] ? 2'b10 : 2'b01;
            default: sym = 2'b00;
        endcase
    end

    // In RUN idx < len_q, so matching ERR_IDX implies ERR_IDX < len.
    assign corrupt = (state == RUN) && inj_q && (32'(idx) == ERR_IDX);

    assign bus.valid    = (state == RUN);
    assign bus.a        = bus.valid ? sym : 2'b00;
    assign bus.b        = bus.a ^ {1'b0, corrupt};
    assign bus.err_beat = corrupt;
    assign busy         = (state == RUN);
    assign done         = (state == DONE);

endmodule

// File: tb/tb_eq2_pattern_gen.sv
// Directed self-checking bench for eq2_pattern_gen.
// Drives command/handshake inputs and compares against hand-derived beats.
module tb_eq2_pattern_gen;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [1:0] mode;
    logic [1:0] fixed_val;
    logic [7:0] len;
    logic       inject_err;
    logic       busy;
    logic       done;

    int vectors;
    int miscompares;

    eq2_pattern_gen_if bus ();

    eq2_pattern_gen dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .mode       (mode),
        .fixed_val  (fixed_val),
        .len        (len),
        .inject_err (inject_err),
        .bus        (bus.master),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        start      = 1'b1;
        mode       = 2'd0;
        fixed_val  = 2'd0;
        len        = 8'd5;
        inject_err = 1'b0;
        bus.ready  = 1'b1;
        tick();
        tick();
        vectors++;
        if ({bus.a, bus.b, bus.valid, busy, done, bus.err_beat} !== 8'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: a=%0d b=%0d v=%0b busy=%0b done=%0b err=%0b, need all 0",
                     bus.a, bus.b, bus.valid, busy, done, bus.err_beat);
        end
        start   = 1'b0;
        reset_n = 1'b1;
        tick();
        vectors++;
        if (bus.valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: valid=%0b busy=%0b, need 0 0", bus.valid, busy);
        end
    endtask

    task automatic test_count();
        logic [1:0] exp_a [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        mode      = 2'd0;
        len       = 8'd6;
        bus.ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (bus.valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 ||
                bus.a !== exp_a[i] || bus.b !== exp_a[i]) begin
                miscompares++;
                $display("FAIL count_beat%0d: v=%0b busy=%0b done=%0b a=%0d b=%0d, need 1 1 0 %0d %0d",
                         i, bus.valid, busy, done, bus.a, bus.b, exp_a[i], exp_a[i]);
            end
            tick();
        end
        vectors++;
        if (bus.valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL count_done: v=%0b done=%0b busy=%0b, need 0 1 0", bus.valid, done, busy);
        end
        tick();
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL count_done_pulse: done=%0b, need 0", done);
        end
    endtask

    task automatic test_lfsr();
        logic [1:0] exp_a [3] = '{2'b01, 2'b10, 2'b01};
        mode      = 2'd1;
        len       = 8'd3;
        bus.ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (bus.valid !== 1'b1 || bus.a !== exp_a[i] || bus.b !== exp_a[i]) begin
                miscompares++;
                $display("FAIL lfsr_beat%0d: v=%0b a=%0d b=%0d, need 1 %0d %0d",
                         i, bus.valid, bus.a, bus.b, exp_a[i], exp_a[i]);
            end
            tick();
        end
        vectors++;
        if (done !== 1'b1 || bus.valid !== 1'b0) begin
            miscompares++;
            $display("FAIL lfsr_done: done=%0b v=%0b, need 1 0", done, bus.valid);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic       pat   [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [1:0] exp_a [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        int acc = 0;
        mode  = 2'd3;
        len   = 8'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            bus.ready = pat[k];
            vectors++;
            if (acc > 3 || bus.valid !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_valid_cyc%0d: v=%0b acc=%0d, need v=1 acc<4", k, bus.valid, acc);
            end else if (bus.a !== exp_a[acc] || bus.b !== exp_a[acc]) begin
                miscompares++;
                $display("FAIL bp_beat_cyc%0d: a=%0d b=%0d, need %0d %0d",
                         k, bus.a, bus.b, exp_a[acc], exp_a[acc]);
            end
            if (pat[k]) acc++;
            tick();
        end
        bus.ready = 1'b1;
        vectors++;
        if (acc !== 4 || done !== 1'b1 || bus.valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_end: transfers=%0d done=%0b v=%0b, need 4 1 0", acc, done, bus.valid);
        end
        tick();
    endtask

    task automatic test_inject();
        logic [1:0] exp_b;
        logic       exp_e;
        mode       = 2'd2;
        fixed_val  = 2'b10;
        len        = 8'd5;
        inject_err = 1'b1;
        bus.ready  = 1'b1;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        inject_err = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_b = (i == 3) ? 2'b11 : 2'b10;
            exp_e = (i == 3);
            vectors++;
            if (bus.valid !== 1'b1 || bus.a !== 2'b10 || bus.b !== exp_b ||
                bus.err_beat !== exp_e) begin
                miscompares++;
                $display("FAIL inj_beat%0d: v=%0b a=%0d b=%0d err=%0b, need 1 2 %0d %0b",
                         i, bus.valid, bus.a, bus.b, bus.err_beat, exp_b, exp_e);
            end
            tick();
        end
        tick();
        len        = 8'd3;
        inject_err = 1'b1;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        inject_err = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (bus.valid !== 1'b1 || bus.a !== 2'b10 || bus.b !== 2'b10 ||
                bus.err_beat !== 1'b0) begin
                miscompares++;
                $display("FAIL inj_short_beat%0d: v=%0b a=%0d b=%0d err=%0b, need 1 2 2 0",
                         i, bus.valid, bus.a, bus.b, bus.err_beat);
            end
            tick();
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL inj_short_done: done=%0b, need 1", done);
        end
        tick();
    endtask

    task automatic test_len_zero();
        len   = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if (done !== 1'b1 || bus.valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL len0: done=%0b v=%0b busy=%0b, need 1 0 0", done, bus.valid, busy);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || bus.valid !== 1'b0) begin
            miscompares++;
            $display("FAIL len0_after: done=%0b v=%0b, need 0 0", done, bus.valid);
        end
    endtask

    task automatic test_reset_mid();
        int seen_done = 0;
        mode      = 2'd0;
        len       = 8'd10;
        bus.ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        vectors++;
        if (bus.a !== 2'd2 || bus.valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_beat2: a=%0d v=%0b, need 2 1", bus.a, bus.valid);
        end
        reset_n = 1'b0;
        tick();
        vectors++;
        if ({bus.a, bus.b, bus.valid, busy, done, bus.err_beat} !== 8'b0) begin
            miscompares++;
            $display("FAIL rstmid_outputs: a=%0d b=%0d v=%0b busy=%0b done=%0b, need all 0",
                     bus.a, bus.b, bus.valid, busy, done);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done === 1'b1 || bus.valid === 1'b1) seen_done++;
        end
        vectors++;
        if (seen_done !== 0) begin
            miscompares++;
            $display("FAIL rstmid_quiet: active cycles=%0d, need 0", seen_done);
        end
    endtask

    task automatic test_back_to_back();
        mode      = 2'd0;
        len       = 8'd3;
        bus.ready = 1'b1;
        start     = 1'b1;
        tick();
        mode      = 2'd2;
        fixed_val = 2'd3;
        len       = 8'd50;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (bus.valid !== 1'b1 || bus.a !== 2'(i)) begin
                miscompares++;
                $display("FAIL held_beat%0d: v=%0b a=%0d, need 1 %0d", i, bus.valid, bus.a, i);
            end
            tick();
        end
        vectors++;
        if (done !== 1'b1 || bus.valid !== 1'b0) begin
            miscompares++;
            $display("FAIL held_done: done=%0b v=%0b, need 1 0", done, bus.valid);
        end
        start = 1'b0;
        tick();
        tick();
        vectors++;
        if (bus.valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL held_idle: v=%0b busy=%0b done=%0b, need 0 0 0", bus.valid, busy, done);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if (bus.valid !== 1'b1 || bus.a !== 2'd3 || bus.b !== 2'd3) begin
            miscompares++;
            $display("FAIL held_restart: v=%0b a=%0d b=%0d, need 1 3 3", bus.valid, bus.a, bus.b);
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_count();
        test_lfsr();
        test_backpressure();
        test_inject();
        test_len_zero();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
